// File: rtl/effect_mem_scheduler.sv
// effect_mem_scheduler
// Per-sample sequencer that owns the single-port sample memory. For each
// start pulse it writes the ADC sample at the circular write pointer, reads
// the chorus tap (LFO-modulated delay) and the reverb tap (fixed delay), then
// mixes the taps into one saturated output word.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   start      one-cycle sample-begin pulse (accepted only in IDLE)
//   sample_in  ADC sample, latched when start is accepted
//   chorus_on  chorus tap enable, sampled in MIX
//   reverb_on  reverb tap enable, sampled in MIX
//   mem_addr   memory address
//   mem_we     memory write enable
//   mem_wdata  zero-extended sample
//   mem_rdata  memory read data, synchronous, 1-cycle latency
//   mix_out    mixed sample
//   mix_valid  one-cycle pulse when mix_out updates
//   busy       high in every state except IDLE
//   overrun    one-cycle pulse, registered: it appears in the cycle after
//              the edge that sampled start in a non-IDLE state
//
// All outputs are registered. Memory controls are computed for the state
// being entered, so each state sees its own address on the bus.

module effect_mem_scheduler #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned REV_DELAY  = 3000,
    parameter int unsigned CHOR_BASE  = 300,
    parameter int unsigned CHOR_DEPTH = 128,
    parameter int unsigned LFO_DIV    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              chorus_on,
    input  logic              reverb_on,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic [DATA_W-1:0] mix_out,
    output logic              mix_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned MEM_W = 16;
    localparam int unsigned SUM_W = DATA_W + 2;
    localparam int unsigned LFO_W = $clog2(CHOR_DEPTH + 1);
    localparam int unsigned CNT_W = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RC   = 3'd2;
    localparam logic [2:0] S_RR   = 3'd3;
    localparam logic [2:0] S_CR   = 3'd4;
    localparam logic [2:0] S_MIX  = 3'd5;

    localparam logic [ADDR_W-1:0] FILL_MAX = '1;
    localparam logic [DATA_W-1:0] SAT_MAX  = '1;

    // state and datapath registers
    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_fill;
    logic [LFO_W-1:0]  r_lfo;
    logic              r_lfo_up;
    logic [CNT_W-1:0]  r_lfo_cnt;
    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] r_chor;
    logic [DATA_W-1:0] r_rev;

    // output registers
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [MEM_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0] r_mix_out;
    logic              r_mix_valid;
    logic              r_busy;
    logic              r_overrun;

    // next-state values
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_wptr_nxt;
    logic [ADDR_W-1:0] w_fill_nxt;
    logic [LFO_W-1:0]  w_lfo_nxt;
    logic              w_lfo_up_nxt;
    logic [CNT_W-1:0]  w_lfo_cnt_nxt;
    logic [DATA_W-1:0] w_sample_nxt;
    logic [DATA_W-1:0] w_chor_nxt;
    logic [DATA_W-1:0] w_rev_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic              w_mem_we_nxt;
    logic [MEM_W-1:0]  w_mem_wdata_nxt;
    logic [DATA_W-1:0] w_mix_out_nxt;
    logic              w_mix_valid_nxt;
    logic              w_overrun_nxt;

    // datapath helpers
    logic [ADDR_W-1:0] w_chor_addr;
    logic [ADDR_W-1:0] w_rev_addr;
    logic              w_chor_ok;
    logic              w_rev_ok;
    logic [SUM_W-1:0]  w_chor_term;
    logic [SUM_W-1:0]  w_rev_term;
    logic [SUM_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_mix_sat;
    logic [LFO_W-1:0]  w_lfo_inc;
    logic [LFO_W-1:0]  w_lfo_dec;
    logic              w_rdata_unused;

    // upper memory bits carry only zero padding
    assign w_rdata_unused = ^mem_rdata[MEM_W-1:DATA_W];

    // tap addresses wrap naturally at ADDR_W bits
    assign w_chor_addr = r_wptr - ADDR_W'(CHOR_BASE) - ADDR_W'(r_lfo);
    assign w_rev_addr  = r_wptr - ADDR_W'(REV_DELAY);

    // warm-up gating keeps unwritten memory out of the mix
    assign w_rev_ok  = (r_fill >= ADDR_W'(REV_DELAY));
    assign w_chor_ok = (r_fill >= ADDR_W'(CHOR_BASE + CHOR_DEPTH));

    // unsigned mix with saturation
    assign w_chor_term = (chorus_on && w_chor_ok) ? SUM_W'(r_chor >> 1) : '0;
    assign w_rev_term  = (reverb_on && w_rev_ok)  ? SUM_W'(r_rev >> 1)  : '0;
    assign w_sum       = SUM_W'(r_sample) + w_chor_term + w_rev_term;
    assign w_mix_sat   = (w_sum > SUM_W'(SAT_MAX)) ? SAT_MAX : w_sum[DATA_W-1:0];

    assign w_lfo_inc = r_lfo + LFO_W'(1);
    assign w_lfo_dec = r_lfo - LFO_W'(1);

    // next-state and registered-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_wptr_nxt      = r_wptr;
        w_fill_nxt      = r_fill;
        w_lfo_nxt       = r_lfo;
        w_lfo_up_nxt    = r_lfo_up;
        w_lfo_cnt_nxt   = r_lfo_cnt;
        w_sample_nxt    = r_sample;
        w_chor_nxt      = r_chor;
        w_rev_nxt       = r_rev;
        w_mem_addr_nxt  = r_wptr;
        w_mem_we_nxt    = 1'b0;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mix_out_nxt   = r_mix_out;
        w_mix_valid_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sample_nxt    = sample_in;
                    w_state_nxt     = S_WR;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_wdata_nxt = MEM_W'(sample_in);
                end
            end
            S_WR: begin
                w_state_nxt    = S_RC;
                w_mem_addr_nxt = w_chor_addr;
            end
            S_RC: begin
                w_state_nxt    = S_RR;
                w_mem_addr_nxt = w_rev_addr;
            end
            S_RR: begin
                // chorus read was issued in RC, data is on the bus now
                w_state_nxt = S_CR;
                w_chor_nxt  = mem_rdata[DATA_W-1:0];
            end
            S_CR: begin
                w_state_nxt = S_MIX;
                w_rev_nxt   = mem_rdata[DATA_W-1:0];
            end
            S_MIX: begin
                w_state_nxt     = S_IDLE;
                w_mix_out_nxt   = w_mix_sat;
                w_mix_valid_nxt = 1'b1;
                w_wptr_nxt      = r_wptr + ADDR_W'(1);
                w_mem_addr_nxt  = r_wptr + ADDR_W'(1);
                if (r_fill != FILL_MAX) begin
                    w_fill_nxt = r_fill + ADDR_W'(1);
                end
                // triangle LFO: one step every LFO_DIV samples
                if (r_lfo_cnt == CNT_W'(LFO_DIV - 1)) begin
                    w_lfo_cnt_nxt = '0;
                    if (r_lfo_up) begin
                        w_lfo_nxt = w_lfo_inc;
                        if (w_lfo_inc == LFO_W'(CHOR_DEPTH)) begin
                            w_lfo_up_nxt = 1'b0;
                        end
                    end else begin
                        w_lfo_nxt = w_lfo_dec;
                        if (w_lfo_dec == '0) begin
                            w_lfo_up_nxt = 1'b1;
                        end
                    end
                end else begin
                    w_lfo_cnt_nxt = r_lfo_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // a start outside IDLE (including MIX) is reported and dropped
        if (start && (r_state != S_IDLE)) begin
            w_overrun_nxt = 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr      <= '0;
            r_fill      <= '0;
            r_lfo       <= '0;
            r_lfo_up    <= 1'b1;
            r_lfo_cnt   <= '0;
            r_sample    <= '0;
            r_chor      <= '0;
            r_rev       <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mix_out   <= '0;
            r_mix_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_fill      <= w_fill_nxt;
            r_lfo       <= w_lfo_nxt;
            r_lfo_up    <= w_lfo_up_nxt;
            r_lfo_cnt   <= w_lfo_cnt_nxt;
            r_sample    <= w_sample_nxt;
            r_chor      <= w_chor_nxt;
            r_rev       <= w_rev_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mix_out   <= w_mix_out_nxt;
            r_mix_valid <= w_mix_valid_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign mix_out   = r_mix_out;
    assign mix_valid = r_mix_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_effect_mem_scheduler.sv
// Directed bench for effect_mem_scheduler with a behavioural synchronous
// memory. The chorus span and LFO divider are shrunk so a full LFO sweep and
// a full write-pointer wrap fit in a short run.

module tb_effect_mem_scheduler;

    localparam int CD = 8;
    localparam int LD = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] sample_in;
    logic        chorus_on;
    logic        reverb_on;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [11:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    int total;
    int bad;

    // behavioural memory with a bench-side preload port
    logic [15:0] mem [0:4095];
    logic        pl_we;
    logic        pl_fill;
    logic [11:0] pl_addr;
    logic [15:0] pl_data;

    effect_mem_scheduler #(
        .ADDR_W(12), .DATA_W(12), .REV_DELAY(3000),
        .CHOR_BASE(300), .CHOR_DEPTH(CD), .LFO_DIV(LD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .sample_in(sample_in),
        .chorus_on(chorus_on), .reverb_on(reverb_on),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mix_out(mix_out), .mix_valid(mix_valid),
        .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_fill) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pl_data;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // triangle LFO value after n completed samples
    function automatic int lfo_at(input int n);
        int s;
        s = (n / LD) % (2 * CD);
        return (s <= CD) ? s : (2 * CD - s);
    endfunction

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // drives one start at a negedge while idle; returns at the negedge where mix_valid is seen
    task automatic run_sample(input logic [11:0] s, output logic wwe, output logic [11:0] wa,
                              output logic [15:0] wd, output logic [11:0] ca, output logic [11:0] ra,
                              output logic [11:0] mo, output int vc, output logic ov, output logic b1);
        wwe = 0; wa = 0; wd = 0; ca = 0; ra = 0; mo = 0; vc = 0; ov = 0; b1 = 0;
        start = 1'b1; sample_in = s;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; wwe = mem_we; wa = mem_addr; wd = mem_wdata; b1 = busy;
            end
            if (k == 2) ca = mem_addr;
            if (k == 3) ra = mem_addr;
            ov = ov | overrun;
            if (mix_valid) begin
                vc = k; mo = mix_out;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; sample_in = '0; chorus_on = 1'b0; reverb_on = 1'b0;
        pl_we = 1'b0; pl_fill = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        total++; if ({mem_we, mem_addr, mem_wdata} !== 29'd0) begin bad++; $display("FAIL reset_mem: got %0h want 0", {mem_we, mem_addr, mem_wdata}); end
        total++; if ({mix_valid, mix_out} !== 13'd0) begin bad++; $display("FAIL reset_mix: got %0h want 0", {mix_valid, mix_out}); end
        total++; if ({busy, overrun} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {busy, overrun}); end
        reset = 1'b1;
        @(negedge clk);
        total++; if ({busy, mem_addr} !== 13'd0) begin bad++; $display("FAIL reset_idle: got %0h want 0", {busy, mem_addr}); end
    endtask

    task automatic test_basic;
        logic wwe, ov, b1; logic [11:0] wa, ca, ra, mo; logic [15:0] wd; int vc;
        run_sample(12'h123, wwe, wa, wd, ca, ra, mo, vc, ov, b1);
        total++; if (wwe !== 1'b1) begin bad++; $display("FAIL basic_we: got %b want 1", wwe); end
        total++; if (wa !== 12'h000) begin bad++; $display("FAIL basic_waddr: got %0h want 0", wa); end
        total++; if (wd !== 16'h0123) begin bad++; $display("FAIL basic_wdata: got %0h want 123", wd); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", b1); end
        total++; if (vc !== 6) begin bad++; $display("FAIL basic_latency: got %0d want 6", vc); end
        total++; if (mo !== 12'h123) begin bad++; $display("FAIL basic_mix: got %0h want 123", mo); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL basic_overrun: got %b want 0", ov); end
        @(negedge clk);
        total++; if (mix_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse: got %b want 0", mix_valid); end
        total++; if ({busy, mem_addr} !== {1'b0, 12'h001}) begin bad++; $display("FAIL basic_wptr: got %0h want 1", {busy, mem_addr}); end
    endtask

    task automatic test_overrun;
        int nv, nw;
        // start during RR
        start = 1'b1; sample_in = 12'h055;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; sample_in = 12'h0AA;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovr_busy: got %b want 1", busy); end
        @(negedge clk); start = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_rr_pulse: got %b want 1", overrun); end
        @(negedge clk);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_rr_clear: got %b want 0", overrun); end
        @(negedge clk);
        total++; if ({mix_valid, mix_out} !== {1'b1, 12'h055}) begin bad++; $display("FAIL ovr_rr_mix: got %0h want 1055", {mix_valid, mix_out}); end
        nv = 0; nw = 0;
        repeat (8) begin @(negedge clk); nv += int'(mix_valid); nw += int'(mem_we); end
        total++; if ({nv, nw} !== {32'd0, 32'd0}) begin bad++; $display("FAIL ovr_rr_extra: got valid=%0d we=%0d want 0 0", nv, nw); end
        total++; if ({busy, mem_addr} !== {1'b0, 12'h002}) begin bad++; $display("FAIL ovr_rr_wptr: got %0h want 2", {busy, mem_addr}); end
        // start coinciding with MIX
        start = 1'b1; sample_in = 12'h066;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; sample_in = 12'h077;
        @(negedge clk); start = 1'b0;
        total++; if ({overrun, mix_valid, mix_out} !== {2'b11, 12'h066}) begin bad++; $display("FAIL ovr_mix: got %0h want 3066", {overrun, mix_valid, mix_out}); end
        nv = 0; nw = 0;
        repeat (8) begin @(negedge clk); nv += int'(mix_valid); nw += int'(mem_we); end
        total++; if ({nv, nw} !== {32'd0, 32'd0}) begin bad++; $display("FAIL ovr_mix_extra: got valid=%0d we=%0d want 0 0", nv, nw); end
        total++; if ({busy, mem_addr} !== {1'b0, 12'h003}) begin bad++; $display("FAIL ovr_mix_wptr: got %0h want 3", {busy, mem_addr}); end
    endtask

    task automatic test_reset_mid;
        int nv;
        start = 1'b1; sample_in = 12'h0AB;
        @(negedge clk); start = 1'b0;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rstmid_wr: got %b want 1", mem_we); end
        #2 reset = 1'b0;
        #1;
        total++; if ({mem_we, busy} !== 2'b00) begin bad++; $display("FAIL rstmid_drop: got %b want 00", {mem_we, busy}); end
        @(negedge clk); reset = 1'b1;
        nv = 0;
        repeat (8) begin @(negedge clk); nv += int'(mix_valid); end
        total++; if (nv !== 0) begin bad++; $display("FAIL rstmid_valid: got %0d want 0", nv); end
        total++; if (mem_addr !== 12'h000) begin bad++; $display("FAIL rstmid_wptr: got %0h want 0", mem_addr); end
    endtask

    task automatic test_warmup;
        logic wwe, ov, b1; logic [11:0] wa, ca, ra, mo, exp; logic [15:0] wd; int vc;
        pl_fill = 1'b1; pl_data = 16'h0FFF;
        @(negedge clk);
        pl_fill = 1'b0;
        reverb_on = 1'b1;
        for (int n = 1; n <= 4096; n++) begin
            chorus_on = (n <= 309);
            run_sample(12'h010, wwe, wa, wd, ca, ra, mo, vc, ov, b1);
            if (n == 309 || n >= 3001) exp = 12'h018;
            else exp = 12'h010;
            total++; if (wa !== 12'(n - 1)) begin bad++; $display("FAIL warm_waddr n=%0d: got %0h want %0h", n, wa, 12'(n - 1)); end
            total++; if (vc !== 6) begin bad++; $display("FAIL warm_latency n=%0d: got %0d want 6", n, vc); end
            total++; if (mo !== exp) begin bad++; $display("FAIL warm_mix n=%0d: got %0h want %0h", n, mo, exp); end
        end
    endtask

    task automatic test_mix;
        logic wwe, ov, b1; logic [11:0] wa, ca, ra, mo; logic [15:0] wd; int vc;
        chorus_on = 1'b1; reverb_on = 1'b1;
        preload(12'd3796, 16'h0400);
        preload(12'd1096, 16'h0800);
        run_sample(12'h100, wwe, wa, wd, ca, ra, mo, vc, ov, b1);
        total++; if (wa !== 12'h000) begin bad++; $display("FAIL mix_wrap_waddr: got %0h want 0", wa); end
        total++; if (ca !== 12'd3796) begin bad++; $display("FAIL mix_rc_addr: got %0d want 3796", ca); end
        total++; if (ra !== 12'd1096) begin bad++; $display("FAIL mix_rr_addr: got %0d want 1096", ra); end
        total++; if (mo !== 12'h700) begin bad++; $display("FAIL mix_sum: got %0h want 700", mo); end
        preload(12'd3797, 16'h0FFF);
        preload(12'd1097, 16'h0FFF);
        run_sample(12'hF00, wwe, wa, wd, ca, ra, mo, vc, ov, b1);
        total++; if ({ca, ra} !== {12'd3797, 12'd1097}) begin bad++; $display("FAIL sat_addrs: got %0d %0d want 3797 1097", ca, ra); end
        total++; if (mo !== 12'hFFF) begin bad++; $display("FAIL sat_mix: got %0h want fff", mo); end
    endtask

    task automatic test_lfo;
        logic wwe, ov, b1; logic [11:0] wa, ca, ra, mo, s; logic [15:0] wd; int vc, n, off;
        chorus_on = 1'b0; reverb_on = 1'b0;
        for (int j = 0; j < 2 * CD * LD + 10; j++) begin
            n = 4098 + j;
            off = 300 + lfo_at(n);
            s = 12'(j * 37 + 5);
            run_sample(s, wwe, wa, wd, ca, ra, mo, vc, ov, b1);
            total++; if (wa !== 12'(n)) begin bad++; $display("FAIL lfo_waddr j=%0d: got %0h want %0h", j, wa, 12'(n)); end
            total++; if (ca !== 12'(n - off)) begin bad++; $display("FAIL lfo_rc_addr j=%0d: got %0d want %0d", j, ca, 12'(n - off)); end
            total++; if (ra !== 12'(n - 3000)) begin bad++; $display("FAIL lfo_rr_addr j=%0d: got %0d want %0d", j, ra, 12'(n - 3000)); end
            total++; if (mo !== s) begin bad++; $display("FAIL lfo_mix j=%0d: got %0h want %0h", j, mo, s); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_basic();
        test_overrun();
        test_reset_mid();
        test_warmup();
        test_mix();
        test_lfo();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
